led_fade_sequencer: RTL
=======================

# led_fade_sequencer

Generates the breathing brightness level for the LED PWM stage. Runs a 1 ms timebase, ramps an 8-bit level 0→255→0 with programmable step rate and dwell, and commits each new level only on the PWM stage's period wrap, so duty changes never glitch mid-period. Sits directly upstream of the PWM comparator; its `brightness` output drives the comparator's threshold.

## Interface
- `CLK_HZ`, default 25_000_000: input clock frequency.
- `TICK_HZ`, default 1000: timebase rate; `DIV = CLK_HZ/TICK_HZ` (must be ≥ 2).
- `clk` in 1: single clock, 25 MHz.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run the sequence while high.
- `step_ms` in 8: ticks per brightness step; 0 is treated as 1.
- `hold_ms` in 16: dwell ticks at peak and trough.
- `pwm_wrap` in 1: single-cycle pulse from the PWM counter at period wrap.
- `brightness` out 8: committed level to the PWM stage.
- `level_update` out 1: one-cycle pulse in the cycle `brightness` takes a new value.
- `rising` out 1: high in RISE and HOLD_HI.

## Operation
- Reset: state IDLE; tick counter 0; step/hold counter 0; staged level 0; `brightness`=0; `level_update`=0; `rising`=0.
- Timebase: counter 0..DIV-1 advances only when state≠IDLE and is cleared in IDLE. `tick` is high for one cycle when counter==DIV-1.
- Config latch: `step_ms` (0→1) and `hold_ms` are captured on IDLE→RISE and on HOLD_LO→RISE. Input changes at other times are ignored until the next latch.
- IDLE: staged=0. `enable`=1 → RISE next cycle.
- RISE: count ticks. On the step_l-th tick: staged+1 and counter cleared. When staged reaches 255 → HOLD_HI, counter cleared.
- HOLD_HI: exit after hold_l ticks → FALL. If hold_l=0, exit on the cycle after entry.
- FALL: mirrors RISE. Staged decrements; reaching 0 → HOLD_LO.
- HOLD_LO: mirrors HOLD_HI. Exit → RISE with a config re-latch.
- `enable`=0 in any state → IDLE next cycle; staged is forced to 0. Takes priority over a simultaneous tick.
- Commit: on `pwm_wrap`, if registered staged ≠ `brightness`, then `brightness` takes staged and `level_update` pulses in the same cycle. Otherwise there is no update and no pulse. Without `pwm_wrap`, `brightness` holds indefinitely, and intermediate staged values may be skipped.
- Arithmetic: staged never wraps. RISE saturates at 255 and FALL at 0 by state exit. Step and hold counters are 16 bits.

## Timing
- `tick` → staged changes on the next clock edge.
- Commit latency: a staged value registered at edge N is committed at the first `pwm_wrap` sampled at edge ≥ N+1. A `pwm_wrap` coincident with the staged update commits the old value.
- `level_update` is registered and aligned with the `brightness` change.
- Full period in ticks is 2·255·step_l + 2·hold_l, plus one clock per state transition. There are no lost ticks at transitions.
- `rst` mid-sequence: all state returns to reset values on the next edge, regardless of `pwm_wrap`.

## Structure
- Shared package/include holds:
  - state encoding: IDLE, RISE, HOLD_HI, FALL, HOLD_LO, 3 bits;
  - `LEVEL_MAX`=255;
  - the `DIV` computation.
- One sub-module: `tick_divider`, with parameter `DIV` and ports `clk`, `rst`, `run`, `tick`. It is reusable for other ms-timebase blocks.
- FSM, staging, and commit logic stay in `led_fade_sequencer`.

## Test plan
Benches use CLK_HZ=1000 and TICK_HZ=100, so DIV=10.
- Reset held 3 cycles then released with `enable`=0 → `brightness`=0, `level_update` never pulses, and the tick counter stays 0.
- `enable`=1, step_ms=1, hold_ms=0, `pwm_wrap` every cycle → `brightness` steps 0→1→…→255 every 10 clocks. `rising` falls as FALL starts, then the level returns to 0.
- step_ms=0 → behaves identically to step_ms=1. step_ms=3, hold_ms=2 → each level lasts 30 clocks, and the peak dwell is 20 clocks plus 1.
- `pwm_wrap` every 25 clocks with step_ms=1 → `brightness` only changes on wrap cycles, some levels are skipped, and `level_update` count equals the number of changes.
- `pwm_wrap` coincident with a staged update → the old staged value is committed, and the new value is committed at the next wrap.
- `enable` dropped at level 100 during RISE → state IDLE next cycle and `brightness`=0 at the next `pwm_wrap`. `rst` asserted at level 200 → `brightness`=0 at the next edge with no wrap needed.

Source files
------------

// File: rtl/led_fade_sequencer_pkg.sv
// Shared definitions for the LED breathing sequencer: state encoding,
// brightness ceiling and timebase divider computation.
package led_fade_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [7:0] LEVEL_MAX = 8'd255;

    // Clocks per timebase tick; callers must keep the result >= 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_fade_sequencer_tick_divider.sv
// Free-running timebase divider. Counts 0..DIV-1 while run is high and
// emits a one-cycle tick on the last count; held at zero while run is low.
module tick_divider #(
    parameter int DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: cleared on reset or when stopped, wraps at DIV-1.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing brightness generator for the LED PWM stage. Ramps a staged level
// 0 -> 255 -> 0 on a millisecond timebase and commits it to the PWM
// threshold only at PWM period wrap so duty never changes mid-period.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | stopped; staged forced to 0, timebase held cleared
//   RISE    | staged +1 every step_l ticks until it reaches 255
//   HOLD_HI | dwell at 255 until hold_l ticks counted, then one clock
//   FALL    | staged -1 every step_l ticks until it reaches 0
//   HOLD_LO | dwell at 0, then re-latch config and restart RISE
module led_fade_sequencer
    import led_fade_sequencer_pkg::*;
#(
    parameter int CLK_HZ  = 25_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  step_ms,
    input  logic [15:0] hold_ms,
    input  logic        pwm_wrap,
    output logic [7:0]  brightness,
    output logic        level_update,
    output logic        rising
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    state_t      state, state_n;
    logic [7:0]  staged, staged_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  step_l, step_l_n;
    logic [15:0] hold_l, hold_l_n;
    logic [7:0]  step_eff;
    logic [16:0] cnt_inc;
    logic        run;
    logic        tick;

    assign run      = (state != IDLE);
    assign step_eff = (step_ms == 8'd0) ? 8'd1 : step_ms;
    // One bit wider so a 65535 hold compares cleanly without overflow.
    assign cnt_inc  = {1'b0, cnt} + 17'd1;

    tick_divider #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // Sequencer next-state, staged level, step/hold counter and config latch.
    always_comb begin
        state_n  = state;
        staged_n = staged;
        cnt_n    = cnt;
        step_l_n = step_l;
        hold_l_n = hold_l;

        case (state)
            IDLE: begin
                staged_n = 8'd0;
                cnt_n    = 16'd0;
                if (enable) begin
                    state_n  = RISE;
                    step_l_n = step_eff;
                    hold_l_n = hold_ms;
                end
            end
            RISE: begin
                if (tick) begin
                    if (cnt_inc == {9'd0, step_l}) begin
                        staged_n = staged + 8'd1;
                        cnt_n    = 16'd0;
                        if (staged == LEVEL_MAX - 8'd1) begin
                            state_n = HOLD_HI;
                        end
                    end else begin
                        cnt_n = cnt_inc[15:0];
                    end
                end
            end
            HOLD_HI: begin
                // Exit is taken the clock after the count is reached, so a
                // zero hold still spends exactly one clock here.
                if (cnt == hold_l) begin
                    state_n = FALL;
                    cnt_n   = 16'd0;
                end else if (tick) begin
                    cnt_n = cnt_inc[15:0];
                end
            end
            FALL: begin
                if (tick) begin
                    if (cnt_inc == {9'd0, step_l}) begin
                        staged_n = staged - 8'd1;
                        cnt_n    = 16'd0;
                        if (staged == 8'd1) begin
                            state_n = HOLD_LO;
                        end
                    end else begin
                        cnt_n = cnt_inc[15:0];
                    end
                end
            end
            HOLD_LO: begin
                if (cnt == hold_l) begin
                    state_n  = RISE;
                    cnt_n    = 16'd0;
                    step_l_n = step_eff;
                    hold_l_n = hold_ms;
                end else if (tick) begin
                    cnt_n = cnt_inc[15:0];
                end
            end
            default: begin
                state_n  = IDLE;
                staged_n = 8'd0;
                cnt_n    = 16'd0;
            end
        endcase

        // Disable wins over any tick or transition in the same cycle.
        if (!enable) begin
            state_n  = IDLE;
            staged_n = 8'd0;
            cnt_n    = 16'd0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            staged <= 8'd0;
            cnt    <= 16'd0;
            step_l <= 8'd0;
            hold_l <= 16'd0;
        end else begin
            state  <= state_n;
            staged <= staged_n;
            cnt    <= cnt_n;
            step_l <= step_l_n;
            hold_l <= hold_l_n;
        end
    end

    // Commit the registered staged level at PWM wrap, pulsing on change only.
    always_ff @(posedge clk) begin
        if (rst) begin
            brightness   <= 8'd0;
            level_update <= 1'b0;
        end else begin
            level_update <= 1'b0;
            if (pwm_wrap && (staged != brightness)) begin
                brightness   <= staged;
                level_update <= 1'b1;
            end
        end
    end

    assign rising = (state == RISE) || (state == HOLD_HI);

endmodule
